// File: rtl/pc_pkg.sv
// Shared types and constants for the PC generator.
// Fetch FSM states, PC increment and default reset vector.
package pc_pkg;

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  localparam int unsigned PC_INC = 4;
  localparam int unsigned DEFAULT_RESET_VEC = 0;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with saturating count.
// A push when full overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   sp;
  logic [PW-1:0]   top_idx;
  logic [CW-1:0]   count;
  logic            do_pop;

  assign top_idx = sp - PW'(1);
  assign do_pop  = pop && !empty;
  assign top     = mem[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == CW'(RAS_DEPTH));

  // sp points at the next free slot; it wraps onto the oldest entry
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sp    <= '0;
      count <= '0;
    end else if (push && do_pop) begin
      sp    <= sp;
      count <= count;
    end else if (push) begin
      sp <= sp + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (do_pop) begin
      sp    <= top_idx;
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !clear)
      mem[do_pop ? top_idx : sp] <= push_data;
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: boot FSM, next-PC priority mux
// and return-address prediction via pc_ras.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC),
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            call_push,
  input  logic            ret_pop,
  input  logic            req_ready,
  output logic            req_valid,
  output logic [XLEN-1:0] pc_out,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);

  state_t          state;
  logic            advance;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] pc_next;

  assign advance = (state == RUN) && req_ready && !stall
                && !trap_valid && !redirect_valid && !rst;
  assign pc_inc  = pc_out + XLEN'(PC_INC);

  always_comb begin
    pc_next = pc_out;
    if (trap_valid)
      pc_next = trap_vec & ALIGN;
    else if (redirect_valid)
      pc_next = redirect_pc & ALIGN;
    else if (!advance)
      pc_next = pc_out;
    else if (ret_pop && !ras_empty)
      pc_next = ras_top & ALIGN;
    else
      pc_next = pc_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT;
      pc_out    <= RESET_VEC;
      req_valid <= 1'b0;
    end else begin
      state     <= RUN;
      pc_out    <= pc_next;
      req_valid <= 1'b1;
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .clear     (trap_valid),
    .push      (advance && call_push),
    .pop       (advance && ret_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, PC width in bits.
REQ-002 Parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, >=2).
REQ-004 clk  in  1  rising-edge clock; one clock domain.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 stall  in  1  hold PC and RAS; no advance.
REQ-007 trap_valid  in  1  exception/flush; load trap_vec.
REQ-008 trap_vec  in  XLEN  trap target.
REQ-009 redirect_valid  in  1  resolved branch/jump; load redirect_pc.
REQ-010 redirect_pc  in  XLEN  branch/jump target.
REQ-011 call_push  in  1  the current PC is a call; push pc_out+4 on advance.
REQ-012 ret_pop  in  1  the current PC is a return; next PC is RAS top on advance.
REQ-013 req_ready  in  1  instruction memory accepts the request.
REQ-014 req_valid  out  1  fetch request valid.
REQ-015 pc_out  out  XLEN  fetch address.
REQ-016 ras_empty / ras_full  out  1 each  RAS occupancy flags.

Function
REQ-017 FSM states: BOOT and RUN. Reset enters BOOT. BOOT -> RUN after exactly 1 cycle. RUN holds until reset.
REQ-018 In BOOT: req_valid=0 and pc_out=RESET_VEC. In RUN: req_valid=1.
REQ-019 An advance occurs when state=RUN, req_ready=1, stall=0, trap_valid=0 and redirect_valid=0.
REQ-020 Next-PC priority, highest first:
- rst -> RESET_VEC
- trap_valid -> trap_vec
- redirect_valid -> redirect_pc
- no advance -> hold pc_out
- advance with ret_pop and RAS non-empty -> RAS top
- otherwise -> pc_out+4
REQ-021 trap_valid and redirect_valid take effect even when stall=1 or req_ready=0; the pending request is abandoned.
REQ-022 Apart from REQ-021, pc_out stays stable while req_valid=1 and req_ready=0.
REQ-023 The low 2 bits of the trap_vec, redirect_pc and RAS values loaded into pc_out are forced to 0.
REQ-024 pc_out+4 wraps modulo 2^XLEN; no overflow flag.
REQ-025 RAS is updated only on advance.
- Push writes pc_out+4 at the top.
- Pop removes the top.
REQ-026 Push and pop in the same advance: next PC = old top; the top entry is replaced by pc_out+4; count is unchanged.
REQ-027 Push when full: the oldest entry is overwritten (circular wrap); count stays RAS_DEPTH; ras_full stays 1.
REQ-028 Pop when empty: next PC = pc_out+4; count stays 0.
REQ-029 trap_valid clears the RAS (count=0). redirect_valid leaves the RAS unchanged.
REQ-030 ras_empty = (count==0); ras_full = (count==RAS_DEPTH); both are registered-state derived with no input combinational paths.

Reset
REQ-031 rst is sampled only at a rising clk edge and overrides all other inputs.
REQ-032 Reset values: state=BOOT, pc_out=RESET_VEC, req_valid=0, RAS count=0, ras_empty=1, ras_full=0.
REQ-033 Reset mid-request (req_valid=1, req_ready=0) drops the request; req_valid=0 on the next cycle.
REQ-034 RAS storage contents need no reset; only the pointer and count are reset.

Structure
REQ-035 Shared package pc_pkg holds:
- the state enum (BOOT, RUN);
- the PC_INC=4 constant;
- the default RESET_VEC constant.
REQ-036 The RAS is one sub-module, pc_ras, parameterised by XLEN and RAS_DEPTH.
- Inputs: push, pop, push_data.
- Outputs: top, empty, full.
REQ-037 pc_gen owns the FSM and next-PC mux; pc_ras owns storage, pointer and count.

Verification
REQ-038 Reset then idle with req_ready=1: pc_out=0, req_valid=0 for 1 cycle; then pc_out=0, 4, 8 on consecutive cycles.
REQ-039 req_ready=0 for 3 cycles at pc=0x10: pc_out holds 0x10; raising stall=1 instead has the same effect; advance resumes to 0x14.
REQ-040 stall=1, redirect_valid=1, redirect_pc=0x103: next pc_out=0x100. Same cycle with trap_valid=1, trap_vec=0x200: pc_out=0x200 and ras_empty=1.
REQ-041 Calls at 0x20, 0x40, 0x60, 0x80, 0xA0 with RAS_DEPTH=4, then 5 returns:
- pops yield 0xA4, 0x84, 0x64, 0x44;
- the 5th pop yields sequential pc+4;
- ras_full=1 after the 4th push.
REQ-042 Push and pop together at pc=0x30 with top=0x54: next pc_out=0x54; new top=0x34; count unchanged.
REQ-043 XLEN=32, pc_out=0xFFFFFFFC, advance: pc_out=0x00000000. Assert rst mid-request: req_valid=0 and pc_out=RESET_VEC next cycle.
